// File: rtl/iscb_unit_sched.sv
// Purpose: time-multiplexes one shared in-stream unary unit among NREQ binary requesters (LFSR SNG in, ones counter out).
// Latency: grant at cycle T -> resp_valid first high at T+2+WARMUP+(2^BW-1).
// Backpressure: result held stable in RESP until resp_ready; no grants are issued while a job is in flight.
// Build option: define ISCB_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module iscb_unit_sched #(
    parameter int NREQ   = 4,
    parameter int BW     = 8,
    parameter int WARMUP = 16,
    parameter int SEED   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*BW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    resp_valid,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic [BW-1:0]           resp_data,
    input  logic                    resp_ready,
    output logic                    unit_clr,
    output logic                    unit_en,
    output logic                    unit_in,
    input  logic                    unit_out
);

    // Galois (right-shift) toggle masks giving a maximal-length sequence for each supported width.
    function automatic logic [BW-1:0] lfsr_taps(input int w);
        case (w)
            3:       return BW'(12'h006);
            4:       return BW'(12'h00C);
            5:       return BW'(12'h014);
            6:       return BW'(12'h030);
            7:       return BW'(12'h060);
            8:       return BW'(12'h0B8);
            9:       return BW'(12'h110);
            10:      return BW'(12'h240);
            11:      return BW'(12'h500);
            default: return BW'(12'hE08);
        endcase
    endfunction

    localparam int            IW        = $clog2(NREQ);
    localparam int            RUNLEN    = (1 << BW) - 1;
    localparam int            PHMAX     = (WARMUP > RUNLEN) ? WARMUP : RUNLEN;
    localparam int            PW        = $clog2(PHMAX + 1);
    localparam logic [PW-1:0] RUN_LAST  = PW'(RUNLEN - 1);
    localparam logic [PW-1:0] WARM_LAST = PW'((WARMUP > 0) ? (WARMUP - 1) : 0);
    localparam logic [BW-1:0] SEED_V    = BW'(SEED);
    localparam logic [BW-1:0] TAPS      = lfsr_taps(BW);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_WARM  = 3'd2,
        S_RUN   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [BW-1:0]   operand;
    logic [BW-1:0]   lfsr;
    logic [BW-1:0]   lfsr_next;
    logic [BW-1:0]   count;
    logic [PW-1:0]   phase;
    logic [IW-1:0]   job_id;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            drive;

`ifdef ISCB_SCHED_RR_EN
    logic [IW-1:0]   rr_ptr;

    // Round-robin pick: first asserted request at or after the pointer, wrapping around.
    always_comb begin
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!gnt_any && req_valid[j]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    // Pointer moves just past the winner on every accepted grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state == S_IDLE && gnt_any) begin
            rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`else
    // Fixed priority pick: lowest asserted index wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(k);
            end
        end
    end
`endif

    // One Galois step; the all-zero state is unreachable from a nonzero seed.
    always_comb begin
        lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: job sequencing and window lengths.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (gnt_any) begin
                    next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                next_state = (WARMUP == 0) ? S_RUN : S_WARM;
            end
            S_WARM: begin
                if (phase == WARM_LAST) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (phase == RUN_LAST) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode: grant pulse, unit control and the response handshake.
    always_comb begin
        req_ready  = '0;
        unit_clr   = 1'b0;
        drive      = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (gnt_any) begin
                    req_ready[gnt_idx] = 1'b1;
                end
            end
            S_CLEAR: unit_clr   = 1'b1;
            S_WARM:  drive      = 1'b1;
            S_RUN:   drive      = 1'b1;
            S_RESP:  resp_valid = 1'b1;
            default: ;
        endcase
        unit_en   = drive;
        unit_in   = drive && (lfsr <= operand);
        resp_data = resp_valid ? count : '0;
        resp_id   = resp_valid ? job_id : '0;
    end

    // Job datapath: operand/id capture, SNG stepping, window phase and ones counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand <= '0;
            job_id  <= '0;
            lfsr    <= SEED_V;
            count   <= '0;
            phase   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        operand <= req_data[int'(gnt_idx)*BW +: BW];
                        job_id  <= gnt_idx;
                    end
                end
                S_CLEAR: begin
                    lfsr  <= SEED_V;
                    count <= '0;
                    phase <= '0;
                end
                S_WARM: begin
                    lfsr  <= lfsr_next;
                    phase <= (phase == WARM_LAST) ? '0 : phase + 1'b1;
                end
                S_RUN: begin
                    lfsr  <= lfsr_next;
                    count <= count + {{(BW-1){1'b0}}, unit_out};
                    phase <= (phase == RUN_LAST) ? '0 : phase + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iscb_unit_sched.sv
// Bench for iscb_unit_sched: identity and behavioural square-root unit models on the unary side,
// randomized requests checked against an arbitration/result model derived from the block's rules,
// plus reset, boundary, back-pressure and mid-job reset scenarios.
module tb_iscb_unit_sched;
    localparam int NREQ   = 4;
    localparam int BW     = 8;
    localparam int WARMUP = 16;
    localparam int LAT    = 2 + WARMUP + ((1 << BW) - 1);

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic [NREQ-1:0]   req_valid  = '0;
    logic [NREQ*BW-1:0] req_data  = '0;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic [1:0]        resp_id;
    logic [BW-1:0]     resp_data;
    logic              resp_ready = 1'b0;
    logic              unit_clr;
    logic              unit_en;
    logic              unit_in;
    logic              unit_out;

    int passed  = 0;
    int total   = 0;
    int cyc     = 0;
    int clr_cnt = 0;
    int m_ptr   = 0;
    bit sqrt_mode = 1'b0;

    // Behavioural sqrt unit: output ones track sqrt(ones_in * cycles) since the last clear.
    int   sq_ones = 0;
    int   sq_n    = 0;
    int   sq_outs = 0;
    real  sq_tgt;
    logic sq_out;

    iscb_unit_sched #(.NREQ(NREQ), .BW(BW), .WARMUP(WARMUP), .SEED(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_ready(resp_ready),
        .unit_clr(unit_clr), .unit_en(unit_en), .unit_in(unit_in), .unit_out(unit_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (unit_clr) clr_cnt <= clr_cnt + 1;
    end

    always_comb begin
        sq_tgt = $sqrt(real'((sq_ones + int'(unit_in)) * (sq_n + 1)));
        sq_out = (real'(sq_outs) + 0.5 <= sq_tgt);
    end

    always @(posedge clk) begin
        if (unit_clr) begin
            sq_ones <= 0; sq_n <= 0; sq_outs <= 0;
        end else if (unit_en) begin
            sq_ones <= sq_ones + int'(unit_in);
            sq_n    <= sq_n + 1;
            sq_outs <= sq_outs + int'(sq_out);
        end
    end

    assign unit_out = sqrt_mode ? sq_out : unit_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model and stimulus helpers ----------------
    function automatic int model_pick(input logic [NREQ-1:0] m);
`ifdef ISCB_SCHED_RR_EN
        for (int k = 0; k < NREQ; k++) if (m[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++) if (m[k]) return k;
`endif
        return -1;
    endfunction

    task automatic model_take(input int g);
        m_ptr = (g + 1) % NREQ;
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [17:0] outs_vec();
        return {req_ready, resp_valid, resp_id, resp_data, unit_clr, unit_en, unit_in};
    endfunction

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(input int budget, output logic [NREQ-1:0] g, output int t);
        g = '0; t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin g = req_ready; t = cyc; return; end
        end
    endtask

    task automatic wait_resp(input int budget, output int t, output logic [1:0] id, output logic [BW-1:0] d);
        t = -1; id = '0; d = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (resp_valid) begin t = cyc; id = resp_id; d = resp_data; return; end
        end
    endtask

    task automatic accept();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic run_job(input logic [NREQ-1:0] mask, input bit hold, output logic [NREQ-1:0] g,
                           output int lat, output logic [1:0] id, output logic [BW-1:0] d);
        int tg, tr;
        req_valid = mask;
        wait_grant(20, g, tg);
        @(posedge clk); #1;
        if (!hold) req_valid = '0;
        wait_resp(LAT + 20, tr, id, d);
        lat = (tg < 0 || tr < 0) ? -1 : tr - tg;
        if (tr >= 0) accept();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (outs_vec() !== 18'd0) $display("FAIL reset_outputs: got %h want 0", outs_vec()); else passed++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (outs_vec() !== 18'd0) $display("FAIL idle_outputs: got %h want 0", outs_vec()); else passed++;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g; int lat, e, c0; logic [1:0] id; logic [BW-1:0] d;
        sync();
        req_data[0 +: BW] = 8'h40;
        e = model_pick(4'b0001);
        c0 = clr_cnt;
        run_job(4'b0001, 1'b0, g, lat, id, d);
        model_take(e);
        total++; if (g !== onehot(e)) $display("FAIL single_grant: got %b want %b", g, onehot(e)); else passed++;
        total++; if (lat !== LAT) $display("FAIL single_latency: got %0d want %0d", lat, LAT); else passed++;
        total++; if (id !== 2'(e)) $display("FAIL single_id: got %0d want %0d", id, e); else passed++;
        total++; if (d !== 8'h40) $display("FAIL single_data: got %h want 40", d); else passed++;
        total++; if (clr_cnt - c0 !== 1) $display("FAIL single_clr_cycles: got %0d want 1", clr_cnt - c0); else passed++;
    endtask

    task automatic test_boundary();
        logic [NREQ-1:0] g; int lat, e; logic [1:0] id; logic [BW-1:0] d;
        req_data[1*BW +: BW] = 8'h00;
        e = model_pick(4'b0010);
        run_job(4'b0010, 1'b0, g, lat, id, d);
        model_take(e);
        total++; if (id !== 2'(e) || d !== 8'h00) $display("FAIL zero_operand: got id %0d data %h want id %0d data 00", id, d, e); else passed++;
        req_data[3*BW +: BW] = 8'hFF;
        e = model_pick(4'b1000);
        run_job(4'b1000, 1'b0, g, lat, id, d);
        model_take(e);
        total++; if (id !== 2'(e) || d !== 8'hFF) $display("FAIL full_operand: got id %0d data %h want id %0d data ff", id, d, e); else passed++;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] g, mask; int lat, e; logic [1:0] id; logic [BW-1:0] d;
        logic [BW-1:0] ops [NREQ];
        for (int j = 0; j < 8; j++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                ops[i] = BW'($urandom_range(0, (1 << BW) - 1));
                req_data[i*BW +: BW] = ops[i];
            end
            e = model_pick(mask);
            run_job(mask, 1'b0, g, lat, id, d);
            model_take(e);
            total++; if (g !== onehot(e)) $display("FAIL rand_grant[%0d]: got %b want %b", j, g, onehot(e)); else passed++;
            total++; if (id !== 2'(e)) $display("FAIL rand_id[%0d]: got %0d want %0d", j, id, e); else passed++;
            total++; if (d !== ops[e]) $display("FAIL rand_data[%0d]: got %h want %h", j, d, ops[e]); else passed++;
        end
    endtask

    task automatic test_arb();
        logic [NREQ-1:0] g; int lat, e; logic [1:0] id; logic [BW-1:0] d;
        logic [BW-1:0] ops [NREQ];
        rst_n = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        sync();
        for (int i = 0; i < NREQ; i++) begin
            ops[i] = BW'(8'h21 + 8'h11 * i);
            req_data[i*BW +: BW] = ops[i];
        end
        for (int j = 0; j < 5; j++) begin
            e = model_pick(4'hF);
            run_job(4'hF, 1'b1, g, lat, id, d);
            model_take(e);
            total++; if (id !== 2'(e)) $display("FAIL arb_id[%0d]: got %0d want %0d", j, id, e); else passed++;
            total++; if (d !== ops[e]) $display("FAIL arb_data[%0d]: got %h want %h", j, d, ops[e]); else passed++;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] g; int tg, tr, e, e2; logic [1:0] id; logic [BW-1:0] d;
        logic [BW-1:0] ops [NREQ];
        sync();
        for (int i = 0; i < NREQ; i++) begin
            ops[i] = BW'($urandom_range(1, 254));
            req_data[i*BW +: BW] = ops[i];
        end
        e = model_pick(4'b0010);
        req_valid = 4'b0010;
        wait_grant(20, g, tg);
        model_take(e);
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(LAT + 20, tr, id, d);
        total++; if (tr < 0 || id !== 2'(e) || d !== ops[e]) $display("FAIL bp_first_resp: got id %0d data %h want id %0d data %h", id, d, e, ops[e]); else passed++;
        req_valid = '1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            total++;
            if ({resp_valid, resp_id, resp_data, req_ready} !== {1'b1, 2'(e), ops[e], 4'b0000})
                $display("FAIL bp_hold[%0d]: got v%b id%0d d%h rdy%b want v1 id%0d d%h rdy0000", i, resp_valid, resp_id, resp_data, req_ready, e, ops[e]);
            else passed++;
        end
        e2 = model_pick(4'hF);
        accept();
        @(negedge clk);
        total++; if (resp_valid !== 1'b0 || req_ready !== onehot(e2)) $display("FAIL bp_idle_after_accept: got v%b rdy%b want v0 rdy%b", resp_valid, req_ready, onehot(e2)); else passed++;
        model_take(e2);
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(LAT + 20, tr, id, d);
        total++; if (tr < 0 || id !== 2'(e2) || d !== ops[e2]) $display("FAIL bp_second_resp: got id %0d data %h want id %0d data %h", id, d, e2, ops[e2]); else passed++;
        if (tr >= 0) accept();
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] g; int tg, lat, e; logic [1:0] id; logic [BW-1:0] d, op0;
        sync();
        req_data[2*BW +: BW] = BW'($urandom_range(0, 255));
        e = model_pick(4'b0100);
        req_valid = 4'b0100;
        wait_grant(20, g, tg);
        model_take(e);
        total++; if (g !== onehot(e)) $display("FAIL mid_grant: got %b want %b", g, onehot(e)); else passed++;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2 + WARMUP + 60) @(negedge clk);
        total++; if (unit_en !== 1'b1) $display("FAIL mid_running: got unit_en %b want 1", unit_en); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (outs_vec() !== 18'd0) $display("FAIL async_reset_outputs: got %h want 0", outs_vec()); else passed++;
        m_ptr = 0;
        repeat (3) @(negedge clk);
        total++; if (outs_vec() !== 18'd0) $display("FAIL held_reset_outputs: got %h want 0", outs_vec()); else passed++;
        rst_n = 1'b1;
        sync();
        op0 = BW'($urandom_range(0, 255));
        req_data[0 +: BW] = op0;
        e = model_pick(4'b0101);
        run_job(4'b0101, 1'b0, g, lat, id, d);
        model_take(e);
        total++; if (g !== 4'b0001) $display("FAIL post_reset_grant: got %b want 0001", g); else passed++;
        total++; if (id !== 2'(e) || d !== op0) $display("FAIL post_reset_resp: got id %0d data %h want id %0d data %h", id, d, e, op0); else passed++;
        total++; if (lat !== LAT) $display("FAIL post_reset_latency: got %0d want %0d", lat, LAT); else passed++;
    endtask

    task automatic test_sqrt();
        logic [NREQ-1:0] g; int lat, e, c0; logic [1:0] id; logic [BW-1:0] d;
        sync();
        sqrt_mode = 1'b1;
        req_data[3*BW +: BW] = 8'h40;
        e = model_pick(4'b1000);
        c0 = clr_cnt;
        run_job(4'b1000, 1'b0, g, lat, id, d);
        model_take(e);
        total++; if (id !== 2'(e)) $display("FAIL sqrt_id: got %0d want %0d", id, e); else passed++;
        total++; if (int'(d) < 8'h78 || int'(d) > 8'h88) $display("FAIL sqrt_data: got %h want 80 +/- 8", d); else passed++;
        total++; if (clr_cnt - c0 !== 1) $display("FAIL sqrt_clr_cycles: got %0d want 1", clr_cnt - c0); else passed++;
        sqrt_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_random();
        test_arb();
        test_backpressure();
        test_reset_mid();
        test_sqrt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/iscb_unit_sched.md
Name: iscb_unit_sched

Overview:
- Time-multiplexes one shared in-stream unary unit (divider/sqrt style; 1-bit in, 1-bit out, internal state) among NREQ binary requesters.
- Per job: latches a BW-bit operand, clears the unit, drives it from an LFSR-based stochastic number generator (SNG) for a warm-up window plus a full measurement window, counts output ones, and returns the count as a BW-bit binary result.
- Sits between binary-domain clients and the unary datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BW, 8, operand/result width; measurement window = 2^BW-1 cycles (3..12).
- WARMUP, 16, cycles the unit runs before counting starts; 0 allowed (WARM state skipped).
- SEED, 1, LFSR reload value at each job start; must be nonzero.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- req_valid  in  NREQ  per-requester request valid
- req_data  in  NREQ*BW  operands; requester i occupies bits [i*BW +: BW]
- req_ready  out  NREQ  one-hot grant/accept pulse
- resp_valid  out  1  result available
- resp_id  out  $clog2(NREQ)  requester index the result belongs to
- resp_data  out  BW  count of unit_out ones over the measurement window
- resp_ready  in  1  consumer accepts result
- unit_clr  out  1  synchronous clear for the shared unit's state
- unit_en  out  1  unit advances state this cycle
- unit_in  out  1  stochastic bit into the unit
- unit_out  in  1  unit output bit, combinational from unit_in in the same cycle

Behaviour:
- Reset values: state=IDLE, all outputs 0; LFSR=SEED; counters, resp_id and operand register 0.
- States: IDLE -> CLEAR -> WARM -> RUN -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, grant exactly one index g: req_ready[g]=1 for that cycle only.
  - Latch req_data[g] and g. Next state is CLEAR.
  - If no req_valid is set, stay in IDLE. req_ready=0 in every other state.
- CLEAR (1 cycle): unit_clr=1, unit_en=0, LFSR<=SEED, count<=0, phase counter<=0.
  - Next state is WARM, or RUN if WARMUP=0.
- WARM (WARMUP cycles):
  - unit_en=1, unit_in=(lfsr<=operand); LFSR steps every cycle.
  - unit_out is ignored.
- RUN (2^BW-1 cycles):
  - Same drive as WARM.
  - count += unit_out at each edge.
- LFSR: BW-bit Galois, maximal-length taps, period 2^BW-1, never 0.
  - Comparison is unsigned; over a full period it yields exactly operand ones (operand 0 gives no ones, 2^BW-1 gives all ones).
- Count width is BW bits. The maximum is 2^BW-1, so the count cannot overflow.
- RESP:
  - resp_valid=1, resp_data=count, resp_id=g; held stable until resp_ready.
  - On the resp_valid&&resp_ready edge, go to IDLE; the next grant is no earlier than the following cycle.
  - unit_en=0 while in RESP.
- Latency: grant at cycle T gives resp_valid first high at T+2+WARMUP+(2^BW-1) (BW=8, WARMUP=16: T+273).
- Arbitration: round-robin.
  - The pointer advances to g+1 (mod NREQ) after each grant.
  - Search starts at the pointer; the pointer resets to 0.
- A requester whose req_valid drops before grant is simply skipped.
- Reset mid-job: immediate return to IDLE, job discarded, no response, pointer reset to 0.
- unit_clr is also asserted during reset deassertion's first cycle? No: only in CLEAR.

Optional Feature:
- Macro ISCB_SCHED_RR_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, where the lowest asserted index always wins and no pointer register is present.
- All other behaviour is identical.

Test Plan:
- Identity unit model (unit_out=unit_in), BW=8, WARMUP=16, req 0 data 0x40 at cycle T -> req_ready[0] at T, resp_valid at T+273, resp_data=0x40, resp_id=0.
- Boundary operands 0x00 and 0xFF on the identity model -> resp_data 0x00 and 0xFF, exact.
- All 4 req_valid held high with distinct data (ISCB_SCHED_RR_EN defined) -> response ids 0,1,2,3,0 in order.
  - Without the macro -> id 0 every job.
- resp_ready held low 50 cycles in RESP -> resp_valid, resp_data and resp_id stable; no req_ready pulses; IDLE one cycle after accept.
- rst_n pulsed low mid-RUN -> all outputs 0 asynchronously; no response for the aborted job; next grant is to req 0 with a fresh, exact count.
- Sqrt behavioural unit model, data 0x40 (0.25) -> resp_data within 0x80±8 (sqrt 0.5); unit_clr exactly one cycle per job.
